// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status layout and FSM states for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h05;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_WREN   = 8'h06;
    localparam logic [7:0] CMD_WRDI   = 8'h04;

    localparam int STAT_WIP = 0;
    localparam int STAT_WEL = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        STATUS,
        READ_DATA,
        PROG_DATA,
        IGNORE
    } state_t;

    function automatic logic [7:0] status_byte(input logic wip, input logic wel);
        logic [7:0] s;
        s           = 8'h00;
        s[STAT_WIP] = wip;
        s[STAT_WEL] = wel;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// Single-port synchronous byte RAM; read data is registered and holds until the next read.
module spi_flash_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_reg [DEPTH];
    logic [7:0] rdata_reg;

    // No reset: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                mem_reg[addr] <= wdata;
            end else begin
                rdata_reg <= mem_reg[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target model: RDSR, WREN, WRDI, READ and page program into an internal byte array.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int MEM_BYTES   = 256,
    parameter int BUSY_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_clk,
    input  logic spi_cs,
    input  logic spi_di,
    output logic spi_do,
    output logic busy_o
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int BW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES + 1) : 1;
    localparam logic [AW-1:0] PAGE_MASK = AW'(255);

    state_t         state_reg, state_next;
    logic           spi_clk_d_reg, cs_d_reg;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [2:0]     out_idx_reg, out_idx_next;
    logic [6:0]     shift_reg, shift_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic [1:0]     addr_bytes_reg, addr_bytes_next;
    logic           is_read_reg, is_read_next;
    logic           prog_seen_reg, prog_seen_next;
    logic           wel_reg, wel_next;
    logic           wip_reg, wip_next;
    logic [BW-1:0]  busy_cnt_reg, busy_cnt_next;
    logic [7:0]     status_reg, status_next;

    logic           sclk_rise, sclk_fall, cs_fall;
    logic [7:0]     rx_byte;
    logic [AW+7:0]  addr_shift;
    logic [AW-1:0]  addr_in;
    logic           mem_en, mem_we;
    logic [AW-1:0]  mem_addr;
    logic [7:0]     mem_rdata, resp_byte;

    assign sclk_rise  = spi_clk & ~spi_clk_d_reg;
    assign sclk_fall  = ~spi_clk & spi_clk_d_reg;
    assign cs_fall    = ~spi_cs & cs_d_reg;
    assign rx_byte    = {shift_reg, spi_di};
    assign addr_shift = {addr_reg, rx_byte};
    assign addr_in    = addr_shift[AW-1:0];

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        out_idx_next    = out_idx_reg;
        shift_next      = shift_reg;
        addr_next       = addr_reg;
        addr_bytes_next = addr_bytes_reg;
        is_read_next    = is_read_reg;
        prog_seen_next  = prog_seen_reg;
        wel_next        = wel_reg;
        wip_next        = wip_reg;
        busy_cnt_next   = busy_cnt_reg;
        status_next     = status_reg;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = addr_reg;

        if (wip_reg) begin
            if (busy_cnt_reg <= BW'(1)) begin
                wip_next      = 1'b0;
                busy_cnt_next = '0;
            end else begin
                busy_cnt_next = busy_cnt_reg - BW'(1);
            end
        end

        // Chip select high wins over any clock edge seen in the same cycle.
        if (spi_cs) begin
            state_next = IDLE;
            if (state_reg == PROG_DATA && prog_seen_reg) begin
                wel_next      = 1'b0;
                wip_next      = 1'b1;
                busy_cnt_next = BW'(BUSY_CYCLES);
            end
        end else if (state_reg == IDLE) begin
            if (cs_fall) begin
                state_next      = CMD;
                bit_cnt_next    = 3'd0;
                addr_bytes_next = 2'd0;
                prog_seen_next  = 1'b0;
            end
        end else if (sclk_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = rx_byte[6:0];
            if (bit_cnt_reg == 3'd7) begin
                out_idx_next = 3'd7;
                case (state_reg)
                    CMD: begin
                        state_next = IGNORE;
                        case (rx_byte)
                            CMD_STATUS: begin
                                state_next  = STATUS;
                                status_next = status_byte(wip_reg, wel_reg);
                            end
                            CMD_READ, CMD_WRITE: begin
                                is_read_next = (rx_byte == CMD_READ);
                                if (!wip_reg && (rx_byte == CMD_READ || wel_reg)) begin
                                    state_next = ADDR;
                                end
                            end
                            CMD_WREN: if (!wip_reg) wel_next = 1'b1;
                            CMD_WRDI: if (!wip_reg) wel_next = 1'b0;
                            default: ;
                        endcase
                    end
                    ADDR: begin
                        addr_next       = addr_in;
                        addr_bytes_next = addr_bytes_reg + 2'd1;
                        if (addr_bytes_reg == 2'd2) begin
                            if (is_read_reg) begin
                                state_next = READ_DATA;
                                mem_en     = 1'b1;
                                mem_addr   = addr_in;
                                addr_next  = addr_in + AW'(1);
                            end else begin
                                state_next = PROG_DATA;
                            end
                        end
                    end
                    STATUS: status_next = status_byte(wip_reg, wel_reg);
                    READ_DATA: begin
                        mem_en    = 1'b1;
                        addr_next = addr_reg + AW'(1);
                    end
                    PROG_DATA: begin
                        mem_en         = 1'b1;
                        mem_we         = 1'b1;
                        prog_seen_next = 1'b1;
                        // Page program wraps within the current 256-byte page.
                        addr_next = (addr_reg & ~PAGE_MASK) | ((addr_reg + AW'(1)) & PAGE_MASK);
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall && bit_cnt_reg != 3'd0) begin
            out_idx_next = ~bit_cnt_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        spi_clk_d_reg <= spi_clk;
        if (rst_i) begin
            state_reg      <= IDLE;
            cs_d_reg       <= 1'b0;
            bit_cnt_reg    <= '0;
            out_idx_reg    <= 3'd7;
            shift_reg      <= '0;
            addr_reg       <= '0;
            addr_bytes_reg <= '0;
            is_read_reg    <= 1'b0;
            prog_seen_reg  <= 1'b0;
            wel_reg        <= 1'b0;
            wip_reg        <= 1'b0;
            busy_cnt_reg   <= '0;
            status_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            cs_d_reg       <= spi_cs;
            bit_cnt_reg    <= bit_cnt_next;
            out_idx_reg    <= out_idx_next;
            shift_reg      <= shift_next;
            addr_reg       <= addr_next;
            addr_bytes_reg <= addr_bytes_next;
            is_read_reg    <= is_read_next;
            prog_seen_reg  <= prog_seen_next;
            wel_reg        <= wel_next;
            wip_reg        <= wip_next;
            busy_cnt_reg   <= busy_cnt_next;
            status_reg     <= status_next;
        end
    end

    spi_flash_mem #(
        .DEPTH(MEM_BYTES),
        .AW   (AW)
    ) u_mem (
        .clk_i(clk_i),
        .en   (mem_en),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(rx_byte),
        .rdata(mem_rdata)
    );

    assign resp_byte = (state_reg == READ_DATA) ? mem_rdata : status_reg;
    assign spi_do    = (!spi_cs && (state_reg == STATUS || state_reg == READ_DATA))
                       ? resp_byte[out_idx_reg] : 1'b1;
    assign busy_o    = wip_reg;

endmodule
